// File: rtl/bsg_async_fifo_rd_ptr_pkg.sv
// Shared helpers for the async FIFO pointer blocks (read and write side).
package bsg_async_fifo_rd_ptr_pkg;

    // Widest pointer the Gray helper handles; callers truncate to their width.
    localparam int max_ptr_width_lp = 32;

    // Pointer width carries one extra wrap bit above the address bits so
    // that full and empty can be told apart.
    function automatic int ptr_width(input int lg_size);
        return lg_size + 1;
    endfunction

    // Single XOR level; adjacent binary values map to codes one bit apart.
    function automatic logic [max_ptr_width_lp-1:0] bin_to_gray(
        input logic [max_ptr_width_lp-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bsg_async_fifo_rd_ptr_if.sv
// Read-side signal bundle between the pointer manager and its consumer.
// Handshake: the head entry is offered while valid_o is high; the consumer
// dequeues it by raising yumi_i in the same cycle (yumi_i must only be raised
// while valid_o is high, otherwise underflow_err_o latches).
interface bsg_async_fifo_rd_ptr_if
    import bsg_async_fifo_rd_ptr_pkg::*;
#(
    parameter int lg_size_p = 4
);
    localparam int ptr_width_lp = ptr_width(lg_size_p);

    logic [ptr_width_lp-1:0] w_ptr_gray_sync_i;
    logic                    yumi_i;
    logic                    valid_o;
    logic [lg_size_p-1:0]    r_addr_o;
    logic [ptr_width_lp-1:0] r_ptr_gray_o;
    logic [ptr_width_lp-1:0] count_o;
    logic                    underflow_err_o;

    // Consumer side: supplies the synchronized write pointer and dequeues.
    modport master (
        output w_ptr_gray_sync_i,
        output yumi_i,
        input  valid_o,
        input  r_addr_o,
        input  r_ptr_gray_o,
        input  count_o,
        input  underflow_err_o
    );

    // Pointer manager side.
    modport slave (
        input  w_ptr_gray_sync_i,
        input  yumi_i,
        output valid_o,
        output r_addr_o,
        output r_ptr_gray_o,
        output count_o,
        output underflow_err_o
    );

endinterface

// File: rtl/bsg_gray_to_binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module bsg_gray_to_binary #(
    parameter int width_p = 5
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] binary_o
);

    // Ripple the XOR down from the MSB.
    always_comb begin
        binary_o = '0;
        binary_o[width_p-1] = gray_i[width_p-1];
        for (int i = width_p - 2; i >= 0; i--) begin
            binary_o[i] = binary_o[i+1] ^ gray_i[i];
        end
    end

endmodule

// File: rtl/bsg_async_fifo_rd_ptr.sv
// Read-domain pointer manager of an asynchronous FIFO. Converts the
// synchronized write pointer to binary, tracks the read pointer, and derives
// valid, occupancy, read address and a flopped Gray pointer for the write side.
module bsg_async_fifo_rd_ptr
    import bsg_async_fifo_rd_ptr_pkg::*;
#(
    parameter int lg_size_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bsg_async_fifo_rd_ptr_if.slave        rd_if
);

    localparam int ptr_width_lp = ptr_width(lg_size_p);

    logic [ptr_width_lp-1:0] w_ptr_bin;
    logic [ptr_width_lp-1:0] r_ptr_bin_q;
    logic [ptr_width_lp-1:0] r_ptr_gray_q;
    logic                    underflow_q;
    logic [ptr_width_lp-1:0] r_ptr_next;
    logic [ptr_width_lp-1:0] r_ptr_gray_next;
    logic [ptr_width_lp-1:0] count;
    logic                    valid;
    logic                    deq;

    bsg_gray_to_binary #(
        .width_p (ptr_width_lp)
    ) w_g2b (
        .gray_i   (rd_if.w_ptr_gray_sync_i),
        .binary_o (w_ptr_bin)
    );

    // Occupancy is the raw modular difference; an out-of-range value means
    // the write side broke the protocol and is flagged by assertion below.
    always_comb begin
        count           = w_ptr_bin - r_ptr_bin_q;
        valid           = (count != '0);
        deq             = rd_if.yumi_i & valid;
        r_ptr_next      = r_ptr_bin_q + 1'b1;
        r_ptr_gray_next = ptr_width_lp'(bin_to_gray(max_ptr_width_lp'(r_ptr_next)));
    end

    // Binary and Gray read pointers advance together on a legal dequeue, so
    // the Gray copy is always the exact encoding of the binary pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr_bin_q  <= '0;
            r_ptr_gray_q <= '0;
        end else if (deq) begin
            r_ptr_bin_q  <= r_ptr_next;
            r_ptr_gray_q <= r_ptr_gray_next;
        end
    end

    // Sticky underflow flag: a dequeue attempt on an empty FIFO.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            underflow_q <= 1'b0;
        end else if (rd_if.yumi_i && !valid) begin
            underflow_q <= 1'b1;
        end
    end

    assign rd_if.valid_o         = valid;
    assign rd_if.count_o         = count;
    assign rd_if.r_addr_o        = r_ptr_bin_q[lg_size_p-1:0];
    assign rd_if.r_ptr_gray_o    = r_ptr_gray_q;
    assign rd_if.underflow_err_o = underflow_q;

    // Occupancy beyond the FIFO depth cannot come from a legal write side.
    a_count_range : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        count <= ptr_width_lp'(1 << lg_size_p)
    );

    // A synchronized Gray pointer may only move one bit per cycle.
    a_w_gray_one_bit : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        $countones(rd_if.w_ptr_gray_sync_i ^ $past(rd_if.w_ptr_gray_sync_i)) <= 1
    );

endmodule

// File: tb/tb_bsg_async_fifo_rd_ptr.sv
// Directed bench for the async FIFO read pointer manager (lg_size_p = 4).
module tb_bsg_async_fifo_rd_ptr;

    localparam int lg_size_lp = 4;
    localparam int pw_lp      = 5;

    typedef struct {
        logic [pw_lp-1:0]      w_gray;
        logic                  yumi;
        logic                  exp_valid;
        logic [pw_lp-1:0]      exp_count;
        logic [lg_size_lp-1:0] exp_addr;
        logic [pw_lp-1:0]      exp_r_gray;
        logic                  exp_err;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_vec  = 0;
    int   n_fail = 0;

    bsg_async_fifo_rd_ptr_if #(.lg_size_p(lg_size_lp)) rd_if ();

    bsg_async_fifo_rd_ptr #(.lg_size_p(lg_size_lp)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .rd_if     (rd_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [pw_lp-1:0] gray(input logic [pw_lp-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // ---------------- driver / checker tasks ----------------
    // Drive inputs after the falling edge; outputs are examined 1 ns later,
    // well away from the next rising edge.
    task automatic apply(input logic [pw_lp-1:0] w, input logic y);
        @(negedge clk);
        rd_if.w_ptr_gray_sync_i = w;
        rd_if.yumi_i            = y;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [pw_lp-1:0] c,
                             input logic [lg_size_lp-1:0] a, input logic [pw_lp-1:0] g,
                             input logic e);
        check({tag, ".valid"}, 32'(rd_if.valid_o), 32'(v));
        check({tag, ".count"}, 32'(rd_if.count_o), 32'(c));
        check({tag, ".addr"},  32'(rd_if.r_addr_o), 32'(a));
        check({tag, ".gray"},  32'(rd_if.r_ptr_gray_o), 32'(g));
        check({tag, ".err"},   32'(rd_if.underflow_err_o), 32'(e));
    endtask

    vec_t vecs[10];

    initial begin
        // Pre-edge expectations: combinational outputs for the applied inputs,
        // registered outputs as left by the previous edge.
        //          w_gray    yumi  valid count     addr  r_gray    err
        vecs[0] = '{5'b00000, 1'b0, 1'b0, 5'd0, 4'd0, 5'b00000, 1'b0}; // reset state
        vecs[1] = '{5'b00001, 1'b0, 1'b1, 5'd1, 4'd0, 5'b00000, 1'b0};
        vecs[2] = '{5'b00011, 1'b0, 1'b1, 5'd2, 4'd0, 5'b00000, 1'b0};
        vecs[3] = '{5'b00010, 1'b0, 1'b1, 5'd3, 4'd0, 5'b00000, 1'b0};
        vecs[4] = '{5'b00010, 1'b1, 1'b1, 5'd3, 4'd0, 5'b00000, 1'b0}; // dequeue 1
        vecs[5] = '{5'b00010, 1'b1, 1'b1, 5'd2, 4'd1, 5'b00001, 1'b0}; // dequeue 2
        vecs[6] = '{5'b00010, 1'b1, 1'b1, 5'd1, 4'd2, 5'b00011, 1'b0}; // dequeue 3
        vecs[7] = '{5'b00010, 1'b0, 1'b0, 5'd0, 4'd3, 5'b00010, 1'b0}; // drained
        vecs[8] = '{5'b00010, 1'b1, 1'b0, 5'd0, 4'd3, 5'b00010, 1'b0}; // illegal yumi
        vecs[9] = '{5'b00010, 1'b0, 1'b0, 5'd0, 4'd3, 5'b00010, 1'b1}; // flag set, ptr held

        reset_n = 1'b0;
        rd_if.w_ptr_gray_sync_i = '0;
        rd_if.yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- table: reset, write-pointer stepping, drain, underflow ----
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].w_gray, vecs[i].yumi);
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_count,
                      vecs[i].exp_addr, vecs[i].exp_r_gray, vecs[i].exp_err);
        end

        // ---- sticky underflow holds for 10+ cycles ----
        for (int i = 0; i < 12; i++) begin
            apply(5'b00010, 1'b0);
            check($sformatf("sticky%0d.err", i), 32'(rd_if.underflow_err_o), 32'd1);
            check($sformatf("sticky%0d.gray", i), 32'(rd_if.r_ptr_gray_o), 32'b00010);
        end

        // ---- asynchronous reset clears the flag without a clock edge ----
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst1.err", 32'(rd_if.underflow_err_o), 32'd0);
        check("rst1.gray", 32'(rd_if.r_ptr_gray_o), 32'd0);
        rd_if.w_ptr_gray_sync_i = '0;
        rd_if.yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- walk the read pointer to 30, one write per cycle ----
        for (int k = 1; k <= 30; k++) begin
            apply(gray(5'(k)), 1'b1);
            check($sformatf("walk%0d.count", k), 32'(rd_if.count_o), 32'd1);
        end
        apply(gray(5'd31), 1'b0);
        apply(gray(5'd0), 1'b0);
        apply(gray(5'd1), 1'b0);
        apply(5'b00011, 1'b0);
        check_all("wrap_pre", 1'b1, 5'd4, 4'd14, 5'b10001, 1'b0);

        // ---- four dequeues across the pointer and address wrap ----
        apply(5'b00011, 1'b1);
        check_all("wrap0", 1'b1, 5'd4, 4'd14, 5'b10001, 1'b0);
        apply(5'b00011, 1'b1);
        check_all("wrap1", 1'b1, 5'd3, 4'd15, 5'b10000, 1'b0);
        apply(5'b00011, 1'b1);
        check_all("wrap2", 1'b1, 5'd2, 4'd0, 5'b00000, 1'b0);
        apply(5'b00011, 1'b1);
        check_all("wrap3", 1'b1, 5'd1, 4'd1, 5'b00001, 1'b0);
        apply(5'b00011, 1'b0);
        check_all("wrap_end", 1'b0, 5'd0, 4'd2, 5'b00011, 1'b0);

        // ---- mid-operation reset with count 5 and a set error flag ----
        apply(5'b00011, 1'b1);
        apply(5'b00011, 1'b0);
        check("mid.err_set", 32'(rd_if.underflow_err_o), 32'd1);
        apply(5'b00010, 1'b0);   // w = 3
        apply(5'b00110, 1'b0);   // w = 4
        apply(5'b00111, 1'b0);   // w = 5
        apply(5'b00101, 1'b0);   // w = 6
        apply(5'b00100, 1'b0);   // w = 7
        check_all("mid_pre", 1'b1, 5'd5, 4'd2, 5'b00011, 1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst.gray", 32'(rd_if.r_ptr_gray_o), 32'd0);
        check("mid_rst.err", 32'(rd_if.underflow_err_o), 32'd0);
        check("mid_rst.addr", 32'(rd_if.r_addr_o), 32'd0);
        check("mid_rst.count", 32'(rd_if.count_o), 32'd7);
        rd_if.w_ptr_gray_sync_i = '0;
        #1;
        check("mid_rst.valid", 32'(rd_if.valid_o), 32'd0);
        check("mid_rst.count0", 32'(rd_if.count_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply(5'b00000, 1'b0);
        check_all("post_rst", 1'b0, 5'd0, 4'd0, 5'b00000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
